// File: rtl/axi4_slave_mem_if.sv
// AXI4 bus bundle for the axi4_slave_mem block: AW, W, B, AR and R channels.
// The master modport is the bus initiator, the slave modport is the memory.
interface axi4_slave_mem_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 4
);
   logic [ID_WIDTH-1:0]     awid;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]              awlen;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic                    wvalid;
   logic                    wready;
   logic [ID_WIDTH-1:0]     bid;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ID_WIDTH-1:0]     arid;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [7:0]              arlen;
   logic                    arvalid;
   logic                    arready;
   logic [ID_WIDTH-1:0]     rid;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rlast;
   logic                    rvalid;
   logic                    rready;

   modport slave (
      input  awid, awaddr, awlen, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

   modport master (
      output awid, awaddr, awlen, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );
endinterface

// File: rtl/axi4_slave_mem.sv
// AXI4 slave backed by a MEM_DEPTH x DATA_WIDTH memory; INCR full-width bursts,
// independent read and write engines, SLVERR on out-of-range beats or bad wlast.
module axi4_slave_mem #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 4,
   parameter int MEM_DEPTH  = 256
) (
   input logic            clk,
   input logic            rst_n,
   axi4_slave_mem_if.slave bus
);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int OFFS   = $clog2(STRB_W);
   localparam int MEM_AW = $clog2(MEM_DEPTH);
   // One spare bit keeps word indices past the top of the address space from wrapping.
   localparam int IDX_W  = ADDR_WIDTH + 1;
   localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_DATA = 2'd1;
   localparam logic [1:0] W_RESP = 2'd2;
   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;

   function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
      return idx[IDX_W-1:MEM_AW] == '0;
   endfunction

   logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

   logic [1:0]            w_state_r;
   logic                  awready_r;
   logic                  wready_r;
   logic                  bvalid_r;
   logic [ID_WIDTH-1:0]   w_id_r;
   logic [ID_WIDTH-1:0]   bid_r;
   logic [1:0]            bresp_r;
   logic [IDX_W-1:0]      w_idx_r;
   logic [7:0]            w_len_r;
   logic [7:0]            w_cnt_r;
   logic                  w_err_r;
   logic                  w_beat_s;
   logic                  w_last_beat_s;
   logic                  w_in_range_s;
   logic                  w_beat_err_s;
   logic                  mem_we_s;

   logic [0:0]            r_state_r;
   logic                  arready_r;
   logic                  rvalid_r;
   logic                  rlast_r;
   logic [ID_WIDTH-1:0]   rid_r;
   logic [DATA_WIDTH-1:0] rdata_r;
   logic [1:0]            rresp_r;
   logic [IDX_W-1:0]      r_idx_r;
   logic [7:0]            r_len_r;
   logic [7:0]            r_cnt_r;
   logic [IDX_W-1:0]      r_next_idx_s;
   logic                  r_next_in_range_s;
   logic [DATA_WIDTH-1:0] r_next_data_s;
   logic [1:0]            r_next_resp_s;

   // Write beat qualification: accepted beat, final-beat flag and per-beat error.
   always_comb begin
      w_beat_s      = (w_state_r == W_DATA) && wready_r && bus.wvalid;
      w_last_beat_s = (w_cnt_r == w_len_r);
      w_in_range_s  = idx_in_range(w_idx_r);
      w_beat_err_s  = !w_in_range_s || (bus.wlast != w_last_beat_s);
      mem_we_s      = w_beat_s && w_in_range_s;
   end

   // Write engine: address capture, beat counting and held write response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_r <= W_IDLE;
         awready_r <= 1'b0;
         wready_r  <= 1'b0;
         bvalid_r  <= 1'b0;
         w_id_r    <= '0;
         bid_r     <= '0;
         bresp_r   <= RESP_OKAY;
         w_idx_r   <= '0;
         w_len_r   <= 8'd0;
         w_cnt_r   <= 8'd0;
         w_err_r   <= 1'b0;
      end else begin
         case (w_state_r)
            W_IDLE: begin
               if (awready_r && bus.awvalid) begin
                  w_id_r    <= bus.awid;
                  w_idx_r   <= {1'b0, bus.awaddr} >> OFFS;
                  w_len_r   <= bus.awlen;
                  w_cnt_r   <= 8'd0;
                  w_err_r   <= 1'b0;
                  awready_r <= 1'b0;
                  wready_r  <= 1'b1;
                  w_state_r <= W_DATA;
               end else begin
                  awready_r <= 1'b1;
               end
            end
            W_DATA: begin
               // The burst length comes from awlen alone; wlast only grades the response.
               if (w_beat_s) begin
                  if (w_last_beat_s) begin
                     wready_r  <= 1'b0;
                     bvalid_r  <= 1'b1;
                     bid_r     <= w_id_r;
                     bresp_r   <= (w_err_r || w_beat_err_s) ? RESP_SLVERR : RESP_OKAY;
                     w_state_r <= W_RESP;
                  end else begin
                     w_cnt_r <= w_cnt_r + 8'd1;
                     w_idx_r <= w_idx_r + IDX_ONE;
                     w_err_r <= w_err_r || w_beat_err_s;
                  end
               end
            end
            W_RESP: begin
               if (bus.bready) begin
                  bvalid_r  <= 1'b0;
                  awready_r <= 1'b1;
                  w_state_r <= W_IDLE;
               end
            end
            default: begin
               w_state_r <= W_IDLE;
               awready_r <= 1'b0;
               wready_r  <= 1'b0;
               bvalid_r  <= 1'b0;
            end
         endcase
      end
   end

   // Byte-masked memory update; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (bus.wstrb[b]) begin
               mem_r[w_idx_r[MEM_AW-1:0]][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
         end
      end
   end

   // Next read beat: first beat from araddr, later beats from the running index.
   always_comb begin
      if (r_state_r == R_IDLE) begin
         r_next_idx_s = {1'b0, bus.araddr} >> OFFS;
      end else begin
         r_next_idx_s = r_idx_r + IDX_ONE;
      end
      r_next_in_range_s = idx_in_range(r_next_idx_s);
      if (r_next_in_range_s) begin
         r_next_data_s = mem_r[r_next_idx_s[MEM_AW-1:0]];
         r_next_resp_s = RESP_OKAY;
      end else begin
         r_next_data_s = '0;
         r_next_resp_s = RESP_SLVERR;
      end
   end

   // Read engine: beats are preloaded into the R registers and held until rready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_r <= R_IDLE;
         arready_r <= 1'b0;
         rvalid_r  <= 1'b0;
         rlast_r   <= 1'b0;
         rid_r     <= '0;
         rdata_r   <= '0;
         rresp_r   <= RESP_OKAY;
         r_idx_r   <= '0;
         r_len_r   <= 8'd0;
         r_cnt_r   <= 8'd0;
      end else begin
         case (r_state_r)
            R_IDLE: begin
               if (arready_r && bus.arvalid) begin
                  rid_r     <= bus.arid;
                  r_idx_r   <= r_next_idx_s;
                  r_len_r   <= bus.arlen;
                  r_cnt_r   <= 8'd0;
                  rdata_r   <= r_next_data_s;
                  rresp_r   <= r_next_resp_s;
                  rlast_r   <= (bus.arlen == 8'd0);
                  rvalid_r  <= 1'b1;
                  arready_r <= 1'b0;
                  r_state_r <= R_DATA;
               end else begin
                  arready_r <= 1'b1;
               end
            end
            R_DATA: begin
               if (rvalid_r && bus.rready) begin
                  if (rlast_r) begin
                     rvalid_r  <= 1'b0;
                     rlast_r   <= 1'b0;
                     arready_r <= 1'b1;
                     r_state_r <= R_IDLE;
                  end else begin
                     r_idx_r <= r_next_idx_s;
                     r_cnt_r <= r_cnt_r + 8'd1;
                     rdata_r <= r_next_data_s;
                     rresp_r <= r_next_resp_s;
                     rlast_r <= ((r_cnt_r + 8'd1) == r_len_r);
                  end
               end
            end
            default: begin
               r_state_r <= R_IDLE;
               arready_r <= 1'b0;
               rvalid_r  <= 1'b0;
               rlast_r   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.awready = awready_r;
   assign bus.wready  = wready_r;
   assign bus.bvalid  = bvalid_r;
   assign bus.bid     = bid_r;
   assign bus.bresp   = bresp_r;
   assign bus.arready = arready_r;
   assign bus.rvalid  = rvalid_r;
   assign bus.rlast   = rlast_r;
   assign bus.rid     = rid_r;
   assign bus.rdata   = rdata_r;
   assign bus.rresp   = rresp_r;
endmodule

// File: tb/tb_axi4_slave_mem.sv
// Self-checking bench for axi4_slave_mem: directed scenarios plus random bursts
// compared against a word-array reference model of the memory.
module tb_axi4_slave_mem;
   localparam int TMO   = 200;
   localparam int DEPTH = 256;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   logic [63:0] model_mem [DEPTH];
   logic [63:0] wbuf_data [256];
   logic [7:0]  wbuf_strb [256];
   logic        wbuf_last [256];

   logic [3:0]  last_bid;
   logic [1:0]  last_bresp;
   logic [63:0] last_rdata;
   logic [1:0]  last_rresp;
   logic        last_rlast;

   axi4_slave_mem_if bus ();

   axi4_slave_mem dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic fill_wbuf(input int len, input bit rand_strb, input bit bad_last);
      int bad;
      bad = $urandom_range(0, len);
      for (int n = 0; n <= len; n++) begin
         wbuf_data[n] = {$urandom, $urandom};
         wbuf_strb[n] = rand_strb ? 8'($urandom) : 8'hFF;
         wbuf_last[n] = (n == len);
         if (bad_last && n == bad) wbuf_last[n] = ~wbuf_last[n];
      end
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
      logic [1:0]  exp_resp;
      logic [63:0] idx;
      int          k;
      bit          tmo;
      exp_resp = 2'b00;
      for (int n = 0; n <= int'(len); n++) begin
         idx = (64'(addr) + 64'(n) * 64'd8) >> 3;
         if (idx < 64'(DEPTH)) begin
            for (int b = 0; b < 8; b++) begin
               if (wbuf_strb[n][b]) model_mem[idx[7:0]][8*b +: 8] = wbuf_data[n][8*b +: 8];
            end
         end else begin
            exp_resp = 2'b10;
         end
         if (wbuf_last[n] != (n == int'(len))) exp_resp = 2'b10;
      end
      @(negedge clk);
      bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awvalid = 1'b1;
      k = 0;
      while (bus.awready !== 1'b1 && k < TMO) begin @(negedge clk); k++; end
      check("aw_handshake", 64'(k < TMO), 64'd1);
      @(negedge clk);
      bus.awvalid = 1'b0;
      tmo = 1'b0;
      for (int n = 0; n <= int'(len); n++) begin
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         bus.wdata = wbuf_data[n]; bus.wstrb = wbuf_strb[n]; bus.wlast = wbuf_last[n];
         bus.wvalid = 1'b1;
         k = 0;
         while (bus.wready !== 1'b1 && k < TMO) begin @(negedge clk); k++; end
         if (k >= TMO) tmo = 1'b1;
         @(negedge clk);
         bus.wvalid = 1'b0;
      end
      check("w_handshake", 64'(tmo), 64'd0);
      check("wready_after_last", 64'(bus.wready), 64'd0);
      k = 0;
      while (bus.bvalid !== 1'b1 && k < TMO) begin @(negedge clk); k++; end
      check("b_handshake", 64'(k < TMO), 64'd1);
      repeat ($urandom_range(0, 2)) begin
         check("bresp_hold", 64'({bus.bvalid, bus.bid, bus.bresp}), 64'({1'b1, id, exp_resp}));
         @(negedge clk);
      end
      check("bid", 64'(bus.bid), 64'(id));
      check("bresp", 64'(bus.bresp), 64'(exp_resp));
      last_bid = bus.bid; last_bresp = bus.bresp;
      bus.bready = 1'b1;
      @(negedge clk);
      bus.bready = 1'b0;
      check("bvalid_clear", 64'(bus.bvalid), 64'd0);
   endtask

   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input bit toggle);
      logic [63:0] idx, exp_data;
      logic [1:0]  exp_resp;
      logic [70:0] saved;
      bit          held;
      int          beat, k;
      @(negedge clk);
      bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arvalid = 1'b1;
      k = 0;
      while (bus.arready !== 1'b1 && k < TMO) begin @(negedge clk); k++; end
      check("ar_handshake", 64'(k < TMO), 64'd1);
      @(negedge clk);
      bus.arvalid = 1'b0;
      beat = 0; k = 0; held = 1'b0; saved = '0;
      while (beat <= int'(len) && k < 4 * TMO) begin
         bus.rready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
         check("rvalid_in_burst", 64'(bus.rvalid), 64'd1);
         if (held) begin
            check("r_stall_stable", {bus.rid, bus.rdata[59:0]}, saved[63:0]);
            check("r_stall_ctl", 64'({bus.rdata[63:60], bus.rresp, bus.rlast}), 64'(saved[70:64]));
         end
         if (bus.rvalid === 1'b1 && bus.rready) begin
            idx = (64'(addr) + 64'(beat) * 64'd8) >> 3;
            if (idx < 64'(DEPTH)) begin
               exp_data = model_mem[idx[7:0]]; exp_resp = 2'b00;
            end else begin
               exp_data = 64'd0; exp_resp = 2'b10;
            end
            check("rdata", bus.rdata, exp_data);
            check("rresp_rlast_rid", 64'({bus.rresp, bus.rlast, bus.rid}),
                  64'({exp_resp, beat == int'(len), id}));
            last_rdata = bus.rdata; last_rresp = bus.rresp; last_rlast = bus.rlast;
            beat++;
            held = 1'b0;
         end else begin
            saved = {bus.rdata[63:60], bus.rresp, bus.rlast, bus.rid, bus.rdata[59:0]};
            held = 1'b1;
         end
         @(negedge clk);
         k++;
      end
      bus.rready = 1'b0;
      check("r_beats_done", 64'(beat), 64'(int'(len) + 1));
      check("rvalid_after_last", 64'(bus.rvalid), 64'd0);
   endtask

   initial begin
      int          k, len, word;
      logic [31:0] addr;
      n_checks = 0; n_fail = 0;
      bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
      bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready_valid", 64'({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid,
            bus.rlast}), 64'd0);
      check("rst_resp_id", 64'({bus.bresp, bus.rresp, bus.bid, bus.rid}), 64'd0);
      check("rst_rdata", bus.rdata, 64'd0);
      rst_n = 1'b1;
      #1;
      check("arready_before_edge", 64'(bus.arready), 64'd0);
      @(negedge clk);
      check("ready_after_release", 64'({bus.awready, bus.arready}), 64'b11);

      // Initialise every word so later reads compare against known contents.
      fill_wbuf(255, 1'b0, 1'b0);
      do_write(4'd0, 32'h0, 8'd255);
      check("fill_bresp", 64'(last_bresp), 64'd0);

      wbuf_data[0] = 64'h1122334455667788; wbuf_strb[0] = 8'hFF; wbuf_last[0] = 1'b1;
      do_write(4'd3, 32'h10, 8'd0);
      check("single_bid", 64'(last_bid), 64'd3);
      check("single_bresp", 64'(last_bresp), 64'd0);
      do_read(4'd5, 32'h10, 8'd0, 1'b0);
      check("single_rdata", last_rdata, 64'h1122334455667788);
      check("single_rlast", 64'(last_rlast), 64'd1);

      fill_wbuf(3, 1'b0, 1'b0);
      do_write(4'd7, 32'h40, 8'd3);
      do_read(4'd9, 32'h40, 8'd3, 1'b1);

      wbuf_data[0] = 64'd0; wbuf_strb[0] = 8'hFF; wbuf_last[0] = 1'b1;
      do_write(4'd1, 32'h20, 8'd0);
      wbuf_data[0] = 64'hFFFF_FFFF_FFFF_FFFF; wbuf_strb[0] = 8'h0F; wbuf_last[0] = 1'b1;
      do_write(4'd1, 32'h20, 8'd0);
      do_read(4'd1, 32'h20, 8'd0, 1'b0);
      check("partial_rdata", last_rdata, 64'h0000_0000_FFFF_FFFF);

      fill_wbuf(1, 1'b0, 1'b0);
      do_write(4'd2, 32'h7F8, 8'd1);
      check("oor_bresp", 64'(last_bresp), 64'd2);
      do_read(4'd2, 32'h7F8, 8'd1, 1'b0);
      check("oor_last_rresp", 64'(last_rresp), 64'd2);
      check("oor_last_rdata", last_rdata, 64'd0);

      fill_wbuf(2, 1'b0, 1'b0);
      wbuf_last[1] = 1'b1;
      do_write(4'd6, 32'h100, 8'd2);
      check("early_wlast_bresp", 64'(last_bresp), 64'd2);
      do_read(4'd6, 32'h100, 8'd2, 1'b1);

      for (int it = 0; it < 24; it++) begin
         len  = $urandom_range(0, 7);
         word = $urandom_range(0, 259);
         addr = 32'(word * 8 + $urandom_range(0, 7));
         fill_wbuf(len, 1'b1, $urandom_range(0, 7) == 0);
         do_write(4'($urandom), addr, 8'(len));
         len  = $urandom_range(0, 7);
         word = $urandom_range(0, 259);
         do_read(4'($urandom), 32'(word * 8), 8'(len), 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of an 8-beat read.
      @(negedge clk);
      bus.arid = 4'd1; bus.araddr = 32'h0; bus.arlen = 8'd7; bus.arvalid = 1'b1;
      k = 0;
      while (bus.arready !== 1'b1 && k < TMO) begin @(negedge clk); k++; end
      check("rst_rd_ar_handshake", 64'(k < TMO), 64'd1);
      @(negedge clk);
      bus.arvalid = 1'b0;
      bus.rready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_rd_midburst", 64'({bus.rvalid, bus.rlast}), 64'b10);
      rst_n = 1'b0;
      #1;
      check("rst_rd_outputs", 64'({bus.rvalid, bus.rlast, bus.arready, bus.rid, bus.rresp}), 64'd0);
      check("rst_rd_rdata", bus.rdata, 64'd0);
      bus.rready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_rd_arready_low", 64'(bus.arready), 64'd0);
      @(negedge clk);
      check("rst_rd_arready_high", 64'({bus.arready, bus.rvalid}), 64'b10);
      do_read(4'd2, 32'h40, 8'd3, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/axi4_slave_mem.md
AXI4_SLAVE_MEM -- requirements
Module: axi4_slave_mem

Interface
REQ-001 SHALL have one clock and reset: clk rising-edge; rst_n asynchronous, active-low.
REQ-002 ADDR_WIDTH, 32, byte-address width.
REQ-003 DATA_WIDTH, 64, data width in bits; power of 2, at least 32.
REQ-004 ID_WIDTH, 4, transaction ID width.
REQ-005 MEM_DEPTH, 256, number of DATA_WIDTH words; power of 2.
REQ-006 clk  in  1  clock.
REQ-007 rst_n  in  1  async active-low reset.
REQ-008 awid  in  ID_WIDTH  write ID.
REQ-009 awaddr  in  ADDR_WIDTH  write start byte address.
REQ-010 awlen  in  8  write beats minus 1.
REQ-011 awvalid  in  1  AW valid.
REQ-012 awready  out  1  AW ready.
REQ-013 wdata  in  DATA_WIDTH  write data.
REQ-014 wstrb  in  DATA_WIDTH/8  byte enables.
REQ-015 wlast  in  1  final write beat marker.
REQ-016 wvalid  in  1  W valid.
REQ-017 wready  out  1  W ready.
REQ-018 bid  out  ID_WIDTH  response ID.
REQ-019 bresp  out  2  write response: 00 OKAY, 10 SLVERR.
REQ-020 bvalid  out  1  B valid.
REQ-021 bready  in  1  B ready.
REQ-022 arid  in  ID_WIDTH  read ID.
REQ-023 araddr  in  ADDR_WIDTH  read start byte address.
REQ-024 arlen  in  8  read beats minus 1.
REQ-025 arvalid  in  1  AR valid.
REQ-026 arready  out  1  AR ready.
REQ-027 rid  out  ID_WIDTH  read ID.
REQ-028 rdata  out  DATA_WIDTH  read data.
REQ-029 rresp  out  2  per-beat read response.
REQ-030 rlast  out  1  final read beat marker.
REQ-031 rvalid  out  1  R valid.
REQ-032 rready  in  1  R ready.

Function
REQ-033 SHALL treat all bursts as INCR, full-width; beat N address = start + N*(DATA_WIDTH/8); word index = address >> log2(DATA_WIDTH/8).
REQ-034 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP.
- W_IDLE: awready=1. A handshake latches awid, awaddr and awlen, then moves to W_DATA.
- W_DATA: wready=1, one beat per wvalid cycle.
- W_RESP: bvalid=1, held with bid/bresp stable until bready, then returns to W_IDLE.
REQ-035 Write burst SHALL end after exactly awlen+1 beats, regardless of wlast. bresp=SLVERR if wlast was missing on the final beat or asserted early; otherwise OKAY unless REQ-037 applies.
REQ-036 Each write beat SHALL update only the bytes whose wstrb bit is 1. The update is visible from the next cycle.
REQ-037 A beat with word index >= MEM_DEPTH SHALL NOT write memory and SHALL force bresp=SLVERR for the whole burst.
REQ-038 Read FSM SHALL have states R_IDLE and R_DATA.
- R_IDLE: arready=1. A handshake latches arid, araddr and arlen, then moves to R_DATA.
- R_DATA: rvalid=1; the beat advances on rvalid&&rready.
- rlast=1 on beat arlen only; after that beat, returns to R_IDLE.
REQ-039 rid, rdata, rresp and rlast SHALL be stable while rvalid=1 and rready=0.
REQ-040 An out-of-range read beat SHALL return rdata=0, rresp=SLVERR; in-range beats return OKAY.
REQ-041 Read and write channels SHALL run concurrently. A read of a word written on the same edge returns the old value.
REQ-042 A write burst crossing the memory end SHALL NOT wrap; writes stop at the boundary per REQ-037.

Reset
REQ-043 rst_n=0 SHALL force both FSMs to idle, even mid-burst.
- Outputs during reset: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0.
- Memory contents are not reset.
REQ-044 awready and arready SHALL rise on the first clk edge after rst_n deasserts.

Verification
REQ-045 Single write 0x10 of 0x1122334455667788 with awid=3 and wstrb=FF, then a read -> bid=3, bresp=00; rdata=0x1122334455667788, rlast=1.
REQ-046 4-beat write to 0x40 (awlen=3), then read with rready toggling -> 4 beats in order, rlast on beat 4 only, data held on stalls.
REQ-047 Partial write wstrb=0x0F of 0xFFFF_FFFF_FFFF_FFFF over a word holding 0 -> readback 0x00000000FFFFFFFF.
REQ-048 Write at 0x7F8 with awlen=1 (second beat out of range) -> bresp=10; readback rresp=00 then 10 with rdata=0.
REQ-049 Early wlast on beat 1 of awlen=2 -> 3 beats accepted, bresp=10.
REQ-050 rst_n pulsed mid 8-beat read -> rvalid=0 immediately; arready=1 on the first edge after release.
